// File: rtl/rvfi_exit_monitor.sv
// RVFI exit monitor: watches commit ports for the terminating store to tohost,
// enforces an optional cycle timeout and keeps retire/trap statistics.
`timescale 1ns/1ps

package riscv;
  localparam int unsigned XLEN = 64;
  localparam int unsigned VLEN = 39;
endpackage

package rvfi_pkg;
  typedef struct packed {
    logic                     valid;
    logic [31:0]              insn;
    logic                     trap;
    logic [riscv::XLEN-1:0]   pc_rdata;
    logic [riscv::XLEN-1:0]   mem_addr;
    logic [riscv::XLEN/8-1:0] mem_wmask;
    logic [riscv::XLEN-1:0]   mem_wdata;
  } rvfi_instr_t;
endpackage

module rvfi_exit_monitor #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned CYCLE_W         = 32,
  parameter int unsigned TRAP_CNT_W      = 32,
  localparam int unsigned PORT_W = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
  input  logic [riscv::XLEN-1:0]                      tohost_addr_i,
  input  logic [CYCLE_W-1:0]                          timeout_cycles_i,
  output logic                                        done_o,
  output logic                                        timeout_o,
  output logic [riscv::XLEN-1:0]                      exit_code_o,
  output logic [riscv::XLEN-1:0]                      exit_pc_o,
  output logic [PORT_W-1:0]                           exit_port_o,
  output logic [CYCLE_W-1:0]                          cycle_cnt_o,
  output logic [63:0]                                 retired_cnt_o,
  output logic [TRAP_CNT_W-1:0]                       trap_cnt_o
);
  localparam int unsigned XLEN  = riscv::XLEN;
  localparam int unsigned VLEN  = riscv::VLEN;
  localparam int unsigned NR    = NR_COMMIT_PORTS;
  localparam int unsigned CNT_W = $clog2(NR_COMMIT_PORTS + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DONE, ST_TIMEOUT} state_e;
  state_e state_q, state_d;

  logic [NR-1:0]     pending_q;
  logic [XLEN-1:0]   captured_q [NR];
  logic [NR-1:0]     match, is_store, term;
  logic              term_any;
  logic [PORT_W-1:0] term_port;
  logic [XLEN-1:0]   term_code, term_pc;
  logic [CNT_W-1:0]  n_valid, n_trap;
  logic              timeout_hit;
  logic [TRAP_CNT_W:0] trap_sum;
  logic              unused_bits;

  always_comb begin
    match       = '0;
    is_store    = '0;
    term        = '0;
    n_valid     = '0;
    n_trap      = '0;
    term_any    = 1'b0;
    term_port   = '0;
    term_code   = '0;
    term_pc     = '0;
    unused_bits = 1'b0;
    for (int i = 0; i < int'(NR); i++) begin
      match[i] = (rvfi_i[i].mem_addr == tohost_addr_i) && (tohost_addr_i != '0) &&
                 (rvfi_i[i].mem_wmask != '0) && (rvfi_i[i].mem_wdata != '0);
      is_store[i] = ((rvfi_i[i].insn[6:0] == 7'b0100011) &&
                     ((rvfi_i[i].insn[14:12] == 3'b010) || (rvfi_i[i].insn[14:12] == 3'b011))) ||
                    ((rvfi_i[i].insn[1:0] == 2'b00) &&
                     ((rvfi_i[i].insn[15:13] == 3'b110) ||
                      ((rvfi_i[i].insn[15:13] == 3'b111) && (XLEN == 64))));
      term[i] = rvfi_i[i].valid && is_store[i] && (pending_q[i] || match[i]);
      n_valid = n_valid + CNT_W'(rvfi_i[i].valid);
      n_trap  = n_trap + CNT_W'(rvfi_i[i].trap && !rvfi_i[i].valid);
      // Lowest-index terminating port wins; a same-cycle write beats the captured value.
      if (term[i] && !term_any) begin
        term_any  = 1'b1;
        term_port = PORT_W'(i);
        term_code = match[i] ? rvfi_i[i].mem_wdata : captured_q[i];
        term_pc   = {{(XLEN-VLEN){rvfi_i[i].pc_rdata[VLEN-1]}}, rvfi_i[i].pc_rdata[VLEN-1:0]};
      end
      unused_bits = unused_bits ^ (^rvfi_i[i].insn[31:16]) ^ (^rvfi_i[i].insn[11:7]) ^
                    (^rvfi_i[i].pc_rdata[XLEN-1:VLEN]);
    end
  end

  assign timeout_hit = (timeout_cycles_i != '0) && (cycle_cnt_o == timeout_cycles_i - CYCLE_W'(1));
  assign trap_sum    = {1'b0, trap_cnt_o} + (TRAP_CNT_W+1)'(n_trap);

  // Termination has priority over a coinciding timeout.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (term_any) begin
        state_d = ST_DONE;
      end else if (timeout_hit) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign done_o    = (state_q == ST_DONE);
  assign timeout_o = (state_q == ST_TIMEOUT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q     <= '0;
      for (int i = 0; i < int'(NR); i++) captured_q[i] <= '0;
      exit_code_o   <= '0;
      exit_pc_o     <= '0;
      exit_port_o   <= '0;
      cycle_cnt_o   <= '0;
      retired_cnt_o <= '0;
      trap_cnt_o    <= '0;
    end else if (state_q == ST_RUN) begin
      cycle_cnt_o   <= cycle_cnt_o + CYCLE_W'(1);
      retired_cnt_o <= retired_cnt_o + 64'(n_valid);
      trap_cnt_o    <= trap_sum[TRAP_CNT_W] ? '1 : trap_sum[TRAP_CNT_W-1:0];
      for (int i = 0; i < int'(NR); i++) begin
        if (match[i]) begin
          pending_q[i]  <= 1'b1;
          captured_q[i] <= rvfi_i[i].mem_wdata;
        end
      end
      if (term_any) begin
        exit_code_o <= term_code;
        exit_pc_o   <= term_pc;
        exit_port_o <= term_port;
      end
    end
  end
endmodule

// File: tb/tb_rvfi_exit_monitor.sv
// Bench for rvfi_exit_monitor: directed scenarios plus random episodes, all
// checked every cycle against a transaction-level model of the exit rules.
`timescale 1ns/1ps

module tb_rvfi_exit_monitor;
  localparam int NR = 2;
  localparam int CW = 8;
  localparam int TW = 4;
  localparam int XL = riscv::XLEN;
  localparam int VL = riscv::VLEN;
  localparam logic [63:0] TOHOST = 64'h0000_0000_8000_1000;
  localparam logic [31:0] I_SD  = 32'h00b53023;
  localparam logic [31:0] I_SW  = 32'h00b52023;
  localparam logic [31:0] I_CSD = 32'h0000e10c;
  localparam logic [31:0] I_CSW = 32'h0000c10c;
  localparam logic [31:0] I_ADD = 32'h00b50533;
  localparam logic [31:0] I_LW  = 32'h00052583;
  localparam logic [31:0] I_SB  = 32'h00b50023;
  localparam logic [31:0] I_CLW = 32'h0000410c;

  // clock / reset / DUT
  logic clk = 1'b0;
  logic rst = 1'b1;
  rvfi_pkg::rvfi_instr_t [NR-1:0] rvfi;
  logic [XL-1:0] tohost;
  logic [CW-1:0] tmo;
  logic          done, timeout;
  logic [XL-1:0] exit_code, exit_pc;
  logic [0:0]    exit_port;
  logic [CW-1:0] cycle_cnt;
  logic [63:0]   retired;
  logic [TW-1:0] trap_cnt;

  always #5 clk = ~clk;

  rvfi_exit_monitor #(.NR_COMMIT_PORTS(NR), .CYCLE_W(CW), .TRAP_CNT_W(TW)) dut (
    .clk_i(clk), .rst_i(rst), .rvfi_i(rvfi), .tohost_addr_i(tohost),
    .timeout_cycles_i(tmo), .done_o(done), .timeout_o(timeout),
    .exit_code_o(exit_code), .exit_pc_o(exit_pc), .exit_port_o(exit_port),
    .cycle_cnt_o(cycle_cnt), .retired_cnt_o(retired), .trap_cnt_o(trap_cnt)
  );

  logic [31:0] insn_tab [8];
  initial insn_tab = '{I_SD, I_SW, I_CSD, I_CSW, I_ADD, I_LW, I_SB, I_CLW};

  // reference model: 0 = running, 1 = exited, 2 = timed out
  int            m_state;
  bit            m_pend [NR];
  logic [XL-1:0] m_capt [NR];
  logic [XL-1:0] m_code, m_pc;
  int            m_port;
  logic [CW-1:0] m_cycle;
  logic [63:0]   m_ret;
  int            m_trap;

  int total = 0;
  int bad   = 0;

  function automatic bit is_store(input logic [31:0] x);
    if (x[6:0] == 7'h23) return (x[14:12] == 3'd2) || (x[14:12] == 3'd3);
    if (x[1:0] == 2'b00) return (x[15:13] == 3'd6) || (x[15:13] == 3'd7);
    return 1'b0;
  endfunction

  function automatic logic [XL-1:0] sext_pc(input logic [XL-1:0] pc);
    logic [XL-1:0] mask;
    mask = (64'd1 << VL) - 64'd1;
    return pc[VL-1] ? ((pc & mask) | ~mask) : (pc & mask);
  endfunction

  task automatic model_reset();
    m_state = 0; m_code = '0; m_pc = '0; m_port = 0;
    m_cycle = '0; m_ret = '0; m_trap = 0;
    for (int i = 0; i < NR; i++) begin m_pend[i] = 1'b0; m_capt[i] = '0; end
  endtask

  task automatic model_step();
    int tp, nv, nt;
    bit hit;
    bit mt [NR];
    logic [XL-1:0] code;
    if (m_state != 0) return;
    tp = -1; nv = 0; nt = 0; code = '0;
    for (int i = 0; i < NR; i++) begin
      mt[i] = (tohost != 0) && (rvfi[i].mem_addr == tohost) &&
              (rvfi[i].mem_wmask != 0) && (rvfi[i].mem_wdata != 0);
      if (rvfi[i].valid) nv++;
      if (rvfi[i].trap && !rvfi[i].valid) nt++;
      if (tp < 0 && rvfi[i].valid && is_store(rvfi[i].insn) && (m_pend[i] || mt[i])) begin
        tp = i;
        code = mt[i] ? rvfi[i].mem_wdata : m_capt[i];
      end
    end
    for (int i = 0; i < NR; i++)
      if (mt[i]) begin m_pend[i] = 1'b1; m_capt[i] = rvfi[i].mem_wdata; end
    m_ret  = m_ret + 64'(nv);
    m_trap = (m_trap + nt > (1 << TW) - 1) ? (1 << TW) - 1 : m_trap + nt;
    hit    = (tmo != 0) && (int'(m_cycle) == int'(tmo) - 1);
    m_cycle = m_cycle + 1'b1;
    if (tp >= 0) begin
      m_state = 1; m_code = code; m_port = tp; m_pc = sext_pc(rvfi[tp].pc_rdata);
    end else if (hit) begin
      m_state = 2;
    end
  endtask

  // scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("done", 64'(done), 64'(m_state == 1));
    check("timeout", 64'(timeout), 64'(m_state == 2));
    check("exit_code", exit_code, m_code);
    check("exit_pc", exit_pc, m_pc);
    check("exit_port", 64'(exit_port), 64'(m_port));
    check("cycle_cnt", 64'(cycle_cnt), 64'(m_cycle));
    check("retired", retired, m_ret);
    check("trap_cnt", 64'(trap_cnt), 64'(m_trap));
  endtask

  // drivers
  task automatic idle();
    rvfi = '0;
  endtask

  task automatic set_port(input int p, input bit v, input bit t, input logic [31:0] insn,
                          input logic [63:0] addr, input logic [7:0] wmask,
                          input logic [63:0] wdata, input logic [63:0] pc);
    rvfi[p].valid = v; rvfi[p].trap = t; rvfi[p].insn = insn;
    rvfi[p].mem_addr = addr; rvfi[p].mem_wmask = wmask;
    rvfi[p].mem_wdata = wdata; rvfi[p].pc_rdata = pc;
  endtask

  task automatic rand_port(input int p);
    rvfi[p].valid     = 1'($urandom_range(0, 1));
    rvfi[p].trap      = ($urandom_range(0, 3) == 0);
    rvfi[p].insn      = insn_tab[$urandom_range(0, 7)];
    rvfi[p].mem_addr  = ($urandom_range(0, 5) == 0) ? tohost : {32'h0, $urandom};
    rvfi[p].mem_wmask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    rvfi[p].mem_wdata = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
    rvfi[p].pc_rdata  = {$urandom, $urandom};
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  // asserted between edges so the clear is seen without any clock
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_done", 64'(done), 64'h0);
    check("rst_code", exit_code, 64'h0);
    check_model();
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    tohost = TOHOST;
    tmo    = '0;
    do_reset();
    check("rst_cycle", 64'(cycle_cnt), 64'h0);
    check("rst_retired", retired, 64'h0);

    // single-cycle SD exit on port 0
    set_port(0, 1, 0, I_SD, TOHOST, 8'hFF, 64'h1, 64'h8000_0040);
    step();
    check("sd_done", 64'(done), 64'h1);
    check("sd_code", exit_code, 64'h1);
    check("sd_port", 64'(exit_port), 64'h0);
    check("sd_pc", exit_pc, 64'h8000_0040);
    check("sd_cycle", 64'(cycle_cnt), 64'h1);
    check("sd_retired", retired, 64'h1);
    idle();
    for (int k = 0; k < 3; k++) begin
      rand_port(0); rand_port(1);
      step();
    end
    check("sd_frozen_cycle", 64'(cycle_cnt), 64'h1);
    do_reset();

    // deferred C.SD exit via a captured write on port 1
    set_port(1, 0, 0, I_CSD, TOHOST, 8'hFF, 64'h3, 64'h0);
    step();
    idle();
    step();
    set_port(1, 1, 0, I_CSD, 64'h2000, 8'hFF, 64'h9, 64'h0000_0040_0000_1000);
    step();
    check("csd_done", 64'(done), 64'h1);
    check("csd_code", exit_code, 64'h3);
    check("csd_port", 64'(exit_port), 64'h1);
    check("csd_pc", exit_pc, 64'hFFFF_FFC0_0000_1000);

    // both ports terminate together
    do_reset();
    set_port(0, 1, 0, I_SW, TOHOST, 8'h0F, 64'h5, 64'h100);
    set_port(1, 1, 0, I_SD, TOHOST, 8'hFF, 64'h7, 64'h104);
    step();
    check("dual_code", exit_code, 64'h5);
    check("dual_port", 64'(exit_port), 64'h0);

    // timeout at 10 cycles, then frozen
    do_reset();
    tmo = 8'd10;
    for (int k = 0; k < 10; k++) step();
    check("to_flag", 64'(timeout), 64'h1);
    check("to_cycle", 64'(cycle_cnt), 64'd10);
    check("to_done", 64'(done), 64'h0);
    for (int k = 0; k < 5; k++) begin
      rand_port(0); rand_port(1);
      step();
    end
    check("to_frozen", 64'(cycle_cnt), 64'd10);

    // exit in the same cycle the timeout would fire
    do_reset();
    for (int k = 0; k < 9; k++) step();
    set_port(0, 1, 0, I_SD, TOHOST, 8'hFF, 64'h42, 64'h0);
    step();
    check("race_done", 64'(done), 64'h1);
    check("race_timeout", 64'(timeout), 64'h0);
    check("race_code", exit_code, 64'h42);
    tmo = '0;

    // disabled tohost, zero data, statistics and trap saturation
    do_reset();
    tohost = '0;
    set_port(0, 1, 0, I_SD, 64'h0, 8'hFF, 64'h5, 64'h0);
    step();
    tohost = TOHOST;
    set_port(0, 1, 0, I_SD, TOHOST, 8'hFF, 64'h0, 64'h0);
    set_port(1, 1, 1, I_ADD, 64'h0, 8'h00, 64'h0, 64'h0);
    step();
    idle();
    set_port(0, 0, 1, I_ADD, 64'h0, 8'h00, 64'h0, 64'h0);
    set_port(1, 0, 1, I_LW, 64'h0, 8'h00, 64'h0, 64'h0);
    step();
    check("stat_done", 64'(done), 64'h0);
    check("stat_retired", retired, 64'd3);
    check("stat_trap", 64'(trap_cnt), 64'd2);
    for (int k = 0; k < 7; k++) step();
    check("trap_sat", 64'(trap_cnt), 64'd15);

    // reset clears a pending write
    do_reset();
    set_port(0, 0, 0, I_ADD, TOHOST, 8'hFF, 64'h9, 64'h0);
    step();
    idle();
    do_reset();
    set_port(0, 1, 0, I_SD, 64'h2000, 8'hFF, 64'h4, 64'h0);
    step();
    check("post_rst_noexit", 64'(done), 64'h0);

    // cycle counter wrap with timeout disabled
    do_reset();
    tohost = '0;
    for (int k = 0; k < 300; k++) begin
      rand_port(0); rand_port(1);
      step();
    end
    check("cycle_wrap", 64'(cycle_cnt), 64'd44);

    // random episodes
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      tohost = ($urandom_range(0, 4) == 0) ? 64'h0 : TOHOST;
      tmo    = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
      for (int k = 0; k < int'($urandom_range(10, 60)); k++) begin
        rand_port(0); rand_port(1);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
